square: RTL and testbench

Sequential integer squarer: computes y = x² for an unsigned 9-bit operand using shift-and-add over 9 iterations. It is the inverse of the 18-bit→9-bit square-root unit. Both sit side by side in the functional-circuitry datapath, with matching start/busy handshake and operand/result widths. The result width covers the full square-root input range, so square(sqrt(n)) ≤ n round-trips can be checked in-system.

---
 rtl/square_pkg.sv | 10 +
 rtl/square_pp.sv | 14 +
 rtl/square.sv | 72 +++++++
 tb/tb_square.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/square_pkg.sv
// square_pkg: widths, iteration count and state encoding shared by the squarer.
package square_pkg;
    localparam int X_W  = 9;
    localparam int Y_W  = 18;
    localparam int ITER = 9;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'b00;
    localparam state_t WORK = 2'b01;
    localparam state_t ADD  = 2'b10;
endpackage

// File: rtl/square_pp.sv
// square_pp: partial product of operand a for bit position ctr (zero when that bit is clear or ctr >= X_W).
module square_pp
    import square_pkg::*;
(
    input  logic [X_W-1:0] a_i,
    input  logic [3:0]     ctr_i,
    output logic [Y_W-1:0] pp_o
);
    logic [X_W-1:0] a_sh;
    always_comb begin
        a_sh = a_i >> ctr_i;
        pp_o = a_sh[0] ? ({{(Y_W-X_W){1'b0}}, a_i} << ctr_i) : '0;
    end
endmodule

// File: rtl/square.sv
// square: sequential 9-bit shift-and-add squarer; defining SQUARE_DONE_EN adds a one-cycle done_o pulse.
module square
    import square_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [X_W-1:0] x_bi,
    output logic [Y_W-1:0] y_bo,
    output logic           busy_o
`ifdef SQUARE_DONE_EN
    , output logic         done_o
`endif
);
    state_t         state_q, state_d;
    logic [X_W-1:0] a_q, a_d;
    logic [Y_W-1:0] acc_q, acc_d, pp_q, pp_d, y_q, y_d, pp_w;
    logic [3:0]     ctr_q, ctr_d;
    logic           fin;
    square_pp u_pp (.a_i(a_q), .ctr_i(ctr_q), .pp_o(pp_w));
    assign fin    = (state_q == WORK) && (ctr_q == 4'(ITER));
    assign busy_o = state_q != IDLE;
    assign y_bo   = y_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        pp_d    = pp_q;
        ctr_d   = ctr_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                state_d = start_i ? WORK : IDLE;
                a_d     = start_i ? x_bi : a_q;
                acc_d   = start_i ? '0 : acc_q;
                ctr_d   = start_i ? '0 : ctr_q;
            end
            WORK: begin
                state_d = fin ? IDLE : ADD;
                y_d     = fin ? acc_q : y_q;
                pp_d    = fin ? pp_q : pp_w;
            end
            ADD: begin
                acc_d   = acc_q + pp_q;
                ctr_d   = ctr_q + 4'd1;
                state_d = WORK;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end
    // datapath registers are fully rewritten before use, so they need no reset
    always_ff @(posedge clk_i) begin
        a_q   <= a_d;
        acc_q <= acc_d;
        pp_q  <= pp_d;
        ctr_q <= ctr_d;
    end
`ifdef SQUARE_DONE_EN
    logic done_q;
    always_ff @(posedge clk_i) done_q <= rst_i ? 1'b0 : fin;
    assign done_o = done_q;
`endif
endmodule

// File: tb/tb_square.sv
// tb_square: randomized scoreboard bench for square against a cycle-count model of x*x.
module tb_square;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [8:0]  x_bi = '0;
    logic [17:0] y_bo;
    logic        busy_o;
`ifdef SQUARE_DONE_EN
    logic        done_o;
`endif
    int total = 0;
    int bad = 0;
    int cnt = 0;
    int cur = 0;
    int y_exp = 0;
    bit done_exp = 0;
    bit last_rst = 1;
    bit prev_busy = 0;
    int q[$];

    square dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .x_bi(x_bi),
        .y_bo(y_bo), .busy_o(busy_o)
`ifdef SQUARE_DONE_EN
        , .done_o(done_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Reference: an accepted operand yields x*x exactly 19 edges later; reset drops any in-flight work.
    initial forever begin
        @(posedge clk_i);
        done_exp = 0;
        if (rst_i) begin
            cnt = 0;
            y_exp = 0;
            q.delete();
            last_rst = 1;
        end else begin
            last_rst = 0;
            if (cnt == 0 && start_i) begin
                cur = int'(x_bi) * int'(x_bi);
                q.push_back(cur);
                cnt = 19;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    y_exp = cur;
                    done_exp = 1;
                end
            end
        end
    end

    initial begin
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            total++;
            if (busy_o !== (cnt > 0)) begin
                bad++;
                $display("FAIL busy t=%0t got=%b want=%b", $time, busy_o, cnt > 0);
            end
            total++;
            if (y_bo !== 18'(y_exp)) begin
                bad++;
                $display("FAIL y_hold t=%0t got=%0d want=%0d", $time, y_bo, y_exp);
            end
`ifdef SQUARE_DONE_EN
            total++;
            if (done_o !== done_exp) begin
                bad++;
                $display("FAIL done t=%0t got=%b want=%b", $time, done_o, done_exp);
            end
`endif
            if (prev_busy && busy_o === 1'b0 && !last_rst) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL result t=%0t got=%0d want=none", $time, y_bo);
                end else begin
                    int e;
                    e = q.pop_front();
                    if (y_bo !== 18'(e)) begin
                        bad++;
                        $display("FAIL result t=%0t got=%0d want=%0d", $time, y_bo, e);
                    end
                end
            end
            prev_busy = (busy_o === 1'b1);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_busy(input logic lvl);
        int n = 0;
        while (busy_o !== lvl && n < 50) begin
            step();
            n++;
        end
        total++;
        if (busy_o !== lvl) begin
            bad++;
            $display("FAIL timeout got=%b want=%b", busy_o, lvl);
        end
    endtask

    task automatic go(input logic [8:0] x);
        start_i = 1'b1;
        x_bi = x;
        step();
        start_i = 1'b0;
        x_bi = 9'($urandom);
    endtask

    initial begin
        step();
        step();
        rst_i = 1'b0;
        step();
        go(9'd0);   wait_busy(1'b0); step();
        go(9'd3);   wait_busy(1'b0); step();
        go(9'd511); wait_busy(1'b0); step();
        for (int i = 0; i < 512; i++) begin
            start_i = 1'b1;
            x_bi = 9'(i);
            wait_busy(1'b1);
            x_bi = 9'($urandom);
            wait_busy(1'b0);
        end
        start_i = 1'b0;
        step();
        go(9'd20);
        repeat (4) step();
        start_i = 1'b1;
        x_bi = 9'd7;
        step();
        start_i = 1'b0;
        wait_busy(1'b0);
        step();
        go(9'd100);
        repeat (9) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        go(9'd12); wait_busy(1'b0); step();
        go(9'd15); wait_busy(1'b0); step();
        rst_i = 1'b1;
        start_i = 1'b1;
        x_bi = 9'd5;
        step();
        rst_i = 1'b0;
        start_i = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 40; i++) begin
            start_i = 1'($urandom);
            x_bi = 9'($urandom);
            step();
        end
        start_i = 1'b0;
        wait_busy(1'b0);
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
